commit_rob: RTL
===============

Name: commit_rob

Overview:
- In-order reorder buffer. Instructions allocate in program order and complete out of order via writeback. Up to two entries retire per cycle in order.
- Produces the 2-wide `cmt_require[1:0]` bundle that the commit stage consumes to write the register file.
- Sits between dispatch/writeback and the commit stage.
- Slots carry no valid bit. The ROB therefore normalises every idle or non-writing slot, so the commit stage's same-address override can never write stale data.

Parameters:
- DEPTH, 8, number of ROB entries; power of two, at least 4.
- TAG_W, $clog2(DEPTH), entry tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (synchronous).
- alloc_valid  in  2  allocation request per slot; legal values are 00, 01 and 11.
- alloc_write_reg_need  in  2  entry writes a GPR.
- alloc_write_reg_addr  in  2x REG_ADDR  destination register per slot.
- alloc_ready  out  1  at least 2 entries free.
- alloc_tag  out  2x TAG_W  tags assigned this cycle (slot0 = tail, slot1 = tail+1).
- wb_valid  in  2  writeback port valid.
- wb_tag  in  2x TAG_W  entry completed.
- wb_result  in  2x REG_WIDTH  result data.
- cmt_require  out  CMT_REQUIRE[1:0]  retired-entry bundle to the commit stage; registered.
- retire_valid  out  2  slot retired last cycle; registered; values 00, 01 or 11.
- rob_empty  out  1  count == 0.

Behaviour:
- Reset interface: clk, with rst synchronous and active-high.
- State:
  - Circular array of {valid, done, write_reg_need, write_reg_addr, result}.
  - head/tail pointers of TAG_W+1 bits (wrap bit).
  - count = tail − head.
- Reset (rst=1 at an edge):
  - All valid/done bits cleared; head = tail = 0.
  - cmt_require all fields 0; retire_valid = 00.
  - Outputs after reset: alloc_ready = 1, rob_empty = 1.
- alloc_ready is combinational: (DEPTH − count) >= 2, using count at the start of the cycle. Same-cycle retirement gives no credit.
- Allocation, on alloc_ready && alloc_valid != 00:
  - Entries written at tail (and tail+1 for 11) with valid=1, done=0. tail advances by popcount.
  - alloc_valid=10 is illegal: it is ignored and no entry is allocated.
  - alloc_tag is always tail and tail+1, regardless of valid.
  - An entry whose write_reg_addr is 0 is stored with write_reg_need=0.
- Writeback:
  - On wb_valid[i], if the entry at wb_tag[i] is valid, set done=1 and store wb_result[i].
  - Writeback to an invalid entry is ignored.
  - Both ports hitting the same tag: port 1 wins.
  - Visible to retirement from the next cycle; no same-cycle bypass.
- Retirement (decided combinationally, registered at the edge):
  - r0 = entry[head].valid && entry[head].done.
  - r1 = r0 && entry[head+1].valid && entry[head+1].done, with head+1 wrapping.
  - Retired entries are cleared to valid=0; head advances by r0+r1.
- Output normalisation for each slot i:
  - If retiring and write_reg_need=1: need=1, addr=entry addr, result=entry result.
  - Otherwise need=0, addr=0, result=0.
  - Consequence: the two slots share an address only when it is 0 or when both genuinely write it (slot1 younger, correct). The regfile hardwires $0.
- Latency: writeback in cycle t → done at edge t → retire decided in cycle t+1 → cmt_require valid in cycle t+2.
- Simultaneous events:
  - alloc, wb and retire may occur in the same cycle on distinct entries.
  - Allocation into entries retiring the same cycle cannot happen (credit rule).
- Flush:
  - Priority: rst > flush > everything else.
  - Flush clears all entries and sets head = tail = 0.
  - It suppresses that cycle's allocation, writeback and retirement; cmt_require is zeroed and retire_valid = 00 next cycle.
  - alloc_ready = 1 the cycle after flush.
- Full boundary (DEPTH=8): count=6 → ready=1; count=7 or 8 → ready=0. Pointers wrap through 7→0 with the wrap bit toggling; full and empty are distinguished by the wrap bit.

Test Plan:
- Reset then allocate 11 with addrs {5,6}, need {1,1}; wb tag1 result 0xB, later tag0 result 0xA → nothing retires until tag0 done; the cycle after the tag0 done edge both retire together (retire_valid=11, cmt_require[0]={1,5,0xA}, [1]={1,6,0xB}).
- Allocate single entry addr 0 with need=1, complete it → retire_valid=01, cmt_require[0].need=0, addr=0; slot1 all zero.
- Retire pair: slot0 need=1 addr 9 result 0x11, slot1 need=0 addr 9 → slot1 driven addr 0, so commit writes $9=0x11.
- Fill 8 entries without completion → alloc_ready=0 once count ≥7; complete and retire 2 → alloc_ready=1; continue 20 allocations across the wrap with in-order retirement and correct tags.
- Flush with 5 entries in flight, some done, while wb and alloc are asserted → next cycle rob_empty=1, retire_valid=00, head=tail=0, and a late writeback to an old tag is ignored.
- Both wb ports target tag 3 with 0x1 and 0x2 in the same cycle → entry 3 retires with result 0x2; alloc_valid=10 → no allocation, tail unchanged.

Source files
------------

// File: rtl/commit_rob_if.sv
// commit_rob_if: dispatch/writeback/commit handshake bundle for the reorder buffer
interface commit_rob_if #(parameter int DEPTH = 8, parameter int RA_W = 5, parameter int RW = 32);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CW = 1 + RA_W + RW;
  logic flush;
  logic [1:0] alloc_valid;
  logic [1:0] alloc_write_reg_need;
  logic [1:0][RA_W-1:0] alloc_write_reg_addr;
  logic alloc_ready;
  logic [1:0][TAG_W-1:0] alloc_tag;
  logic [1:0] wb_valid;
  logic [1:0][TAG_W-1:0] wb_tag;
  logic [1:0][RW-1:0] wb_result;
  logic [1:0][CW-1:0] cmt_require;
  logic [1:0] retire_valid;
  logic rob_empty;
  modport master (
    output flush, alloc_valid, alloc_write_reg_need, alloc_write_reg_addr, wb_valid, wb_tag, wb_result,
    input alloc_ready, alloc_tag, cmt_require, retire_valid, rob_empty
  );
  modport slave (
    input flush, alloc_valid, alloc_write_reg_need, alloc_write_reg_addr, wb_valid, wb_tag, wb_result,
    output alloc_ready, alloc_tag, cmt_require, retire_valid, rob_empty
  );
endinterface

// File: rtl/commit_rob.sv
// commit_rob: in-order reorder buffer, 2-wide alloc/writeback, up to 2 in-order retirements per cycle
// cmt_require slot layout is {need, addr, result}; non-retiring or non-writing slots are driven all zero.
module commit_rob #(parameter int DEPTH = 8, parameter int RA_W = 5, parameter int RW = 32) (
  input logic clk,
  input logic rst,
  commit_rob_if.slave rob
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CW = 1 + RA_W + RW;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0] ptr_t;
  logic [DEPTH-1:0] valid_q, done_q, need_q;
  logic [DEPTH-1:0][RA_W-1:0] addr_q;
  logic [DEPTH-1:0][RW-1:0] res_q;
  ptr_t head_q, tail_q, count, free;
  logic [1:0][CW-1:0] cmt_q;
  logic [1:0] ret_q;
  tag_t [1:0] h, t;
  logic [1:0] r;
  logic do_alloc;
  always_comb begin
    count = tail_q - head_q;
    free = ptr_t'(DEPTH) - count;
    h[0] = head_q[TAG_W-1:0];
    h[1] = h[0] + 1'b1;
    t[0] = tail_q[TAG_W-1:0];
    t[1] = t[0] + 1'b1;
    r[0] = valid_q[h[0]] & done_q[h[0]];
    r[1] = r[0] & valid_q[h[1]] & done_q[h[1]];
    // 10 is illegal and has bit0 clear, so bit0 alone qualifies a request
    do_alloc = (free >= ptr_t'(2)) & rob.alloc_valid[0];
  end
  assign rob.alloc_ready = free >= ptr_t'(2);
  assign rob.alloc_tag = t;
  assign rob.rob_empty = count == '0;
  assign rob.cmt_require = cmt_q;
  assign rob.retire_valid = ret_q;
  always_ff @(posedge clk) begin
    if (rst || rob.flush) begin
      valid_q <= '0;
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cmt_q <= '0;
      ret_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r[i]) valid_q[h[i]] <= 1'b0;
        cmt_q[i] <= (r[i] && need_q[h[i]]) ? {1'b1, addr_q[h[i]], res_q[h[i]]} : '0;
      end
      // port 1 is evaluated last so it wins a same-tag collision
      for (int i = 0; i < 2; i++)
        if (rob.wb_valid[i] && valid_q[rob.wb_tag[i]]) begin
          done_q[rob.wb_tag[i]] <= 1'b1;
          res_q[rob.wb_tag[i]] <= rob.wb_result[i];
        end
      if (do_alloc) begin
        for (int i = 0; i < 2; i++)
          if (rob.alloc_valid[i]) begin
            valid_q[t[i]] <= 1'b1;
            done_q[t[i]] <= 1'b0;
            need_q[t[i]] <= rob.alloc_write_reg_need[i] && (rob.alloc_write_reg_addr[i] != '0);
            addr_q[t[i]] <= rob.alloc_write_reg_addr[i];
          end
        tail_q <= tail_q + (rob.alloc_valid[1] ? ptr_t'(2) : ptr_t'(1));
      end
      head_q <= head_q + ptr_t'(r[0]) + ptr_t'(r[1]);
      ret_q <= r;
    end
  end
endmodule
